// File: rtl/median_tile_rasterizer.sv
// Reorders 3x12 median-filter tiles into raster-order 12-pixel row segments.
// Ping-pong storage lets one band be written while the previous band streams out.
module median_tile_rasterizer #(
    parameter int PIX_W         = 8,
    parameter int TILE_W        = 12,
    parameter int TILE_H        = 3,
    parameter int TILES_PER_ROW = 53,
    parameter int BANDS         = 160
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [TILE_H*TILE_W*PIX_W-1:0]   in_pixels,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TILE_W*PIX_W-1:0]          out_pixels,
    output logic                             out_sol,
    output logic                             out_eol,
    output logic                             out_sof,
    output logic                             out_eof,
    output logic                             overflow
);

    localparam int SEG_W   = TILE_W * PIX_W;
    localparam int TILE_CW = $clog2(TILES_PER_ROW);
    localparam int ROW_CW  = $clog2(TILE_H);
    localparam int BAND_CW = $clog2(BANDS);

    localparam logic [TILE_CW-1:0] LAST_TILE = TILE_CW'(TILES_PER_ROW - 1);
    localparam logic [ROW_CW-1:0]  LAST_ROW  = ROW_CW'(TILE_H - 1);
    localparam logic [BAND_CW-1:0] LAST_BAND = BAND_CW'(BANDS - 1);

    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic [TILE_CW-1:0] r_wr_tile;
    logic               r_rd_bank;
    logic [ROW_CW-1:0]  r_rd_row;
    logic [TILE_CW-1:0] r_rd_seg;
    logic [BAND_CW-1:0] r_rd_band;
    logic               r_overflow;

    logic               w_wr_fire;
    logic               w_wr_last;
    logic               w_rd_fire;
    logic               w_seg_last;
    logic               w_row_last;
    logic               w_rd_last;
    logic [1:0]         w_full_set;
    logic [1:0]         w_full_clr;
    logic [1:0]         w_full_nxt;
    logic [SEG_W-1:0]   w_row_data [TILE_H];

    assign in_ready   = ~r_full[r_wr_bank];
    assign w_wr_fire  = in_valid & in_ready;
    assign w_wr_last  = w_wr_fire & (r_wr_tile == LAST_TILE);

    assign out_valid  = r_full[r_rd_bank];
    assign w_rd_fire  = out_valid & out_ready;
    assign w_seg_last = (r_rd_seg == LAST_TILE);
    assign w_row_last = (r_rd_row == LAST_ROW);
    assign w_rd_last  = w_rd_fire & w_seg_last & w_row_last;

    // The completing write and the completing read always target different banks.
    assign w_full_set = w_wr_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_rd_last ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_full_nxt = (r_full & ~w_full_clr) | w_full_set;

    // One storage array per tile row so each tile lands in a single cycle.
    for (genvar g = 0; g < TILE_H; g++) begin : g_row
        logic [SEG_W-1:0] r_mem [2][TILES_PER_ROW];

        // Row g of the accepted tile into the current write bank/slot.
        always_ff @(posedge clk) begin
            if (w_wr_fire) begin
                r_mem[r_wr_bank][r_wr_tile] <= in_pixels[(TILE_H-1-g)*SEG_W +: SEG_W];
            end
        end

        assign w_row_data[g] = r_mem[r_rd_bank][r_rd_seg];
    end

    assign out_pixels = w_row_data[r_rd_row];

    // Bank occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Write-side slot and bank counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_tile <= {TILE_CW{1'b0}};
            r_wr_bank <= 1'b0;
        end else if (w_wr_fire) begin
            if (w_wr_last) begin
                r_wr_tile <= {TILE_CW{1'b0}};
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_tile <= r_wr_tile + TILE_CW'(1);
            end
        end
    end

    // Read-side segment/row/band counters; they only move on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_seg  <= {TILE_CW{1'b0}};
            r_rd_row  <= {ROW_CW{1'b0}};
            r_rd_bank <= 1'b0;
            r_rd_band <= {BAND_CW{1'b0}};
        end else if (w_rd_fire) begin
            if (w_seg_last) begin
                r_rd_seg <= {TILE_CW{1'b0}};
                if (w_row_last) begin
                    r_rd_row  <= {ROW_CW{1'b0}};
                    r_rd_bank <= ~r_rd_bank;
                    r_rd_band <= (r_rd_band == LAST_BAND) ? {BAND_CW{1'b0}}
                                                          : r_rd_band + BAND_CW'(1);
                end else begin
                    r_rd_row <= r_rd_row + ROW_CW'(1);
                end
            end else begin
                r_rd_seg <= r_rd_seg + TILE_CW'(1);
            end
        end
    end

    // Sticky record of any tile offered while storage was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
    assign out_sol  = out_valid & (r_rd_seg == {TILE_CW{1'b0}});
    assign out_eol  = out_valid & w_seg_last;
    assign out_sof  = out_valid & (r_rd_band == {BAND_CW{1'b0}}) &
                      (r_rd_row == {ROW_CW{1'b0}}) & (r_rd_seg == {TILE_CW{1'b0}});
    assign out_eof  = out_valid & (r_rd_band == LAST_BAND) & w_row_last & w_seg_last;

endmodule

// File: tb/tb_median_tile_rasterizer.sv
// Self-checking bench: a band-level queue model predicts every beat, flag and handshake.
module tb_median_tile_rasterizer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [287:0] in_pixels;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  out_pixels;
    logic         out_sol;
    logic         out_eol;
    logic         out_sof;
    logic         out_eof;
    logic         overflow;

    median_tile_rasterizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_pixels  (in_pixels),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixels (out_pixels),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [95:0] d;
        logic [3:0]  f;   // {sol, eol, sof, eof}
    } beat_t;

    beat_t        q[$];
    logic [287:0] m_tiles [53];
    int           m_ntile;
    int           m_bands;
    bit           m_ovf;
    int           n_tests;
    int           n_fail;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [287:0] rnd_tile();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    function automatic logic [287:0] pat_tile(input int tn);
        logic [287:0] t;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 12; c++)
                t[(35 - (r*12 + c))*8 +: 8] = 8'(tn) ^ 8'(r*16 + c);
        return t;
    endfunction

    // Complete bands unlocked for output; model is full-band granular.
    function automatic int pending_bands();
        return (q.size() + 158) / 159;
    endfunction

    task automatic accept(input logic [287:0] d);
        beat_t b;
        int    band;
        m_tiles[m_ntile] = d;
        m_ntile++;
        if (m_ntile == 53) begin
            m_ntile = 0;
            band = m_bands % 160;
            for (int r = 0; r < 3; r++) begin
                for (int s = 0; s < 53; s++) begin
                    b.d    = m_tiles[s][(2-r)*96 +: 96];
                    b.f[3] = (s == 0);
                    b.f[2] = (s == 52);
                    b.f[1] = (band == 0) && (r == 0) && (s == 0);
                    b.f[0] = (band == 159) && (r == 2) && (s == 52);
                    q.push_back(b);
                end
            end
            m_bands++;
        end
    endtask

    task automatic check_outputs();
        bit exp_v;
        bit exp_r;
        exp_v = (q.size() != 0);
        exp_r = (pending_bands() < 2);
        chk("out_valid", out_valid, exp_v);
        chk("in_ready", in_ready, exp_r);
        chk("overflow", overflow, m_ovf);
        if (exp_v) begin
            chk("out_pixels", out_pixels, q[0].d);
            chk("flags", {out_sol, out_eol, out_sof, out_eof}, q[0].f);
        end else begin
            chk("flags_idle", {out_sol, out_eol, out_sof, out_eof}, 4'b0000);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input bit iv, input bit orr, input logic [287:0] d);
        bit    m_v;
        bit    m_r;
        beat_t b;
        check_outputs();
        m_v       = (q.size() != 0);
        m_r       = (pending_bands() < 2);
        in_valid  = iv;
        out_ready = orr;
        in_pixels = d;
        @(posedge clk);
        if (m_v && orr) b = q.pop_front();
        if (iv && m_r) accept(d);
        else if (iv) m_ovf = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit iv, input bit orr);
        for (int i = 0; i < n; i++) cycle(iv, orr, rnd_tile());
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 2000) begin
            cycle(1'b0, 1'b1, rnd_tile());
            g++;
        end
        cycle(1'b0, 1'b1, rnd_tile());
    endtask

    initial begin
        int g;
        n_tests   = 0;
        n_fail    = 0;
        m_ntile   = 0;
        m_bands   = 0;
        m_ovf     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pixels = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;

        // One band of patterned tiles streamed with the sink always ready.
        for (int t = 0; t < 53; t++) cycle(1'b1, 1'b1, pat_tile(t));
        drain();

        // Fill both banks while stalled, then one tile too many.
        run(107, 1'b1, 1'b0);
        chk("ovf_sticky", overflow, 1'b1);
        drain();

        // Random back-pressure while a band is written and read.
        g = 0;
        while ((m_bands < 4 || q.size() != 0) && g < 3000) begin
            cycle((m_bands < 4) && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 1) == 1, rnd_tile());
            g++;
        end

        // Finish the frame and start the next one (eof then sof).
        g = 0;
        while ((m_bands < 162 || q.size() != 0) && g < 40000) begin
            cycle(m_bands < 162, $urandom_range(0, 9) != 0, rnd_tile());
            g++;
        end

        // Last tile into bank 0 coincides with the final beat of bank 1.
        run(106, 1'b1, 1'b0);
        run(159, 1'b0, 1'b1);
        run(52, 1'b1, 1'b0);
        run(158, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        chk("coinc_out_valid", out_valid, 1'b1);
        chk("coinc_in_ready", in_ready, 1'b1);
        drain();

        // Asynchronous reset in the middle of row 1, segment 20.
        run(53, 1'b1, 1'b0);
        run(73, 1'b0, 1'b1);
        chk("mid_seg20_eol", out_eol, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_sol", out_sol, 1'b0);
        q.delete();
        m_ntile = 0;
        m_bands = 0;
        m_ovf   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(53, 1'b1, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
